// File: rtl/dec_arb_pkg.sv
// dec_arb_pkg: shared constants, state encoding and helpers for the 3-to-8
// select-decoder arbiter (dec_sel_arbiter) and its round-robin picker (rr_pick8).
//
// Contents:
//   N_REQ, SEL_W        requester count and select width
//   HOLD_MAX_DEF        default maximum grant length in clocks (timeout build only)
//   GAP_CYC_DEF         default break-before-make gap in clocks
//   arb_state_e         FSM encoding IDLE/BUSY/GAP
//   sel_onehot()        select index -> one-hot grant vector
package dec_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [15:0] HOLD_MAX_DEF = 16'd1000;
  localparam logic [3:0]  GAP_CYC_DEF  = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/dec_sel_arbiter_rr_pick8.sv
// rr_pick8: combinational round-robin search over eight request lines.
// The search starts at ptr and walks upward modulo 8; the first set request wins.
//
// Ports:
//   req    in   8  request vector
//   ptr    in   3  index with highest priority this round
//   found  out  1  at least one request is set
//   idx    out  3  winning index (0 when found is low)
module rr_pick8
  import dec_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      // 3-bit add wraps 7 -> 0, giving the modulo-8 walk for free
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dec_sel_arbiter.sv
// dec_sel_arbiter: round-robin arbiter/sequencer in front of the 3-to-8 select
// decoder. Grants one requester at a time, holds the grant while the owner keeps
// requesting, and inserts GAP_CYC idle clocks between owners (break-before-make).
// sel[0]/sel[1]/sel[2] feed decoder inputs in1/in2/in3.
//
// Optional feature: define DEC_ARB_TIMEOUT_EN to build the hold counter, which
// forcibly revokes a grant after HOLD_MAX clocks and pulses timeout for one cycle.
// Without it the grant lasts until release and timeout is tied low.
//
// Parameters:
//   HOLD_MAX  maximum grant length in clocks (1..65535, timeout build only)
//   GAP_CYC   clocks with no grant between two owners (1..15)
// Ports:
//   sys_clk  in   1  clock, rising edge
//   sys_rst  in   1  asynchronous active-high reset
//   req      in   8  level requests
//   sel      out  3  registered owner index, holds last value when idle
//   gnt      out  8  registered one-hot grant, 0 when not busy
//   busy     out  1  registered, high while a grant is active
//   timeout  out  1  one-cycle pulse after a HOLD_MAX revocation
module dec_sel_arbiter
  import dec_arb_pkg::*;
#(
  parameter logic [15:0] HOLD_MAX = HOLD_MAX_DEF,
  parameter logic [3:0]  GAP_CYC  = GAP_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       gap_q, gap_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             grant;
  logic             leave;
  logic             hold_expire;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef DEC_ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d, hold_inc;
  logic        timeout_q, timeout_d;

  // hold_inc is the number of BUSY clocks including the current one; it
  // saturates so a huge HOLD_MAX can never be skipped by wrap-around.
  assign hold_inc    = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
  assign hold_expire = (hold_inc == HOLD_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    grant   = 1'b0;
    leave   = 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) grant = 1'b1;
      end
      BUSY: begin
        // Release wins over a coincident timeout: no pulse in that case.
        if (!req[sel_q]) begin
          leave = 1'b1;
        end else if (hold_expire) begin
          leave = 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
        end else begin
`ifdef DEC_ARB_TIMEOUT_EN
          hold_d = hold_inc;
`endif
        end
      end
      GAP: begin
        if (gap_q >= GAP_CYC) begin
          if (pick_found) grant = 1'b1;
          else            state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (leave) begin
      state_d = GAP;
      gnt_d   = '0;
      busy_d  = 1'b0;
      // The clock following this edge is the first gap clock.
      gap_d   = 4'd1;
    end

    if (grant) begin
      state_d = BUSY;
      sel_d   = pick_idx;
      gnt_d   = sel_onehot(pick_idx);
      busy_d  = 1'b1;
      ptr_d   = pick_idx + 3'd1;
`ifdef DEC_ARB_TIMEOUT_EN
      hold_d  = 16'd0;
`endif
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gap_q   <= 4'd0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dec_sel_arbiter.sv
// tb_dec_sel_arbiter: self-checking bench for dec_sel_arbiter.
// Expected owners are queued when requests are driven and popped when a grant
// appears. Timeout expectations follow DEC_ARB_TIMEOUT_EN.
module tb_dec_sel_arbiter;
  import dec_arb_pkg::*;

  localparam logic [15:0] HOLD = 16'd5;
  localparam logic [3:0]  GAP  = 4'd2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 sys_clk = ~sys_clk;

  dec_sel_arbiter #(
    .HOLD_MAX (HOLD),
    .GAP_CYC  (GAP)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Ticks until a grant is visible; n is the number of edges taken.
  task automatic wait_gnt(input int limit, output int n);
    n = 0;
    while (gnt == 8'd0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < int'(GAP) + 2; i++) tick();
  endtask

  task automatic pulse_reset();
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'd0;
    sys_rst = 1'b0;
    #1;
    sys_rst = 1'b1;
    #2;
    checks++; if (gnt !== 8'd0) $display("FAIL reset_gnt: got %0h want 0", gnt);
    if (gnt !== 8'd0) errors++;
    checks++; if (sel !== 3'd0) begin $display("FAIL reset_sel: got %0d want 0", sel); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", busy); errors++; end
    checks++;
    if (timeout !== 1'b0) begin $display("FAIL reset_timeout: got %0b want 0", timeout); errors++; end
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    int owner;
    exp_q.push_back(3);
    req = 8'h08;
    wait_gnt(4, n);
    checks++; if (n !== 1) begin $display("FAIL single_latency: got %0d want 1", n); errors++; end
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL single_sel: got %0d want %0d", sel, owner); errors++; end
    checks++;
    if (gnt !== (8'd1 << owner)) begin
      $display("FAIL single_gnt: got %0h want %0h", gnt, 8'd1 << owner); errors++;
    end
    checks++; if (busy !== 1'b1) begin $display("FAIL single_busy: got %0b want 1", busy); errors++; end
    tick();
    checks++; if (gnt !== 8'h08) begin $display("FAIL single_hold: got %0h want 08", gnt); errors++; end
    req = 8'd0;
    tick();
    checks++; if (gnt !== 8'd0) begin $display("FAIL single_release: got %0h want 0", gnt); errors++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL single_rel_busy: got %0b want 0", busy); errors++; end
    checks++; if (sel !== 3'd3) begin $display("FAIL single_sel_hold: got %0d want 3", sel); errors++; end
    drain();
  endtask

  task automatic test_rotation();
    int n;
    int owner;
    pulse_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    req = 8'hFF;
    wait_gnt(4, n);
    checks++; if (n !== 1) begin $display("FAIL rot_first_latency: got %0d want 1", n); errors++; end
    for (int k = 0; k < 9; k++) begin
      owner = exp_q.pop_front();
      checks++;
      if (sel !== 3'(owner)) begin
        $display("FAIL rot_sel[%0d]: got %0d want %0d", k, sel, owner); errors++;
      end
      checks++;
      if (gnt !== (8'd1 << owner)) begin
        $display("FAIL rot_gnt[%0d]: got %0h want %0h", k, gnt, 8'd1 << owner); errors++;
      end
      tick();
      req[owner] = 1'b0;
      tick();
      checks++;
      if (gnt !== 8'd0) begin $display("FAIL rot_release[%0d]: got %0h want 0", k, gnt); errors++; end
      if (k < 8) begin
        req[owner] = 1'b1;
        wait_gnt(3 * int'(GAP) + 4, n);
        checks++;
        if (n !== int'(GAP)) begin
          $display("FAIL rot_gap[%0d]: got %0d want %0d", k, n, GAP); errors++;
        end
      end else begin
        req = 8'd0;
      end
    end
    drain();
  endtask

  task automatic test_ptr_wrap();
    int n;
    int owner;
    exp_q.push_back(7);
    exp_q.push_back(0);
    req = 8'h80;
    wait_gnt(4, n);
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL wrap_first: got %0d want %0d", sel, owner); errors++; end
    req = 8'd0;
    tick();
    checks++; if (gnt !== 8'd0) begin $display("FAIL wrap_release: got %0h want 0", gnt); errors++; end
    req = 8'h81;
    wait_gnt(3 * int'(GAP) + 4, n);
    checks++; if (n !== int'(GAP)) begin $display("FAIL wrap_gap: got %0d want %0d", n, GAP); errors++; end
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL wrap_sel: got %0d want %0d", sel, owner); errors++; end
    checks++;
    if (gnt !== (8'd1 << owner)) begin
      $display("FAIL wrap_gnt: got %0h want %0h", gnt, 8'd1 << owner); errors++;
    end
    req = 8'd0;
    tick();
    drain();
  endtask

  task automatic test_timeout();
    int n;
    int owner;
`ifdef DEC_ARB_TIMEOUT_EN
    int ones;
    exp_q.push_back(2);
    exp_q.push_back(2);
    req = 8'h04;
    wait_gnt(4, n);
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL to_sel: got %0d want %0d", sel, owner); errors++; end
    ones = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt !== 8'h04) break;
      ones++;
    end
    checks++; if (ones !== int'(HOLD)) begin $display("FAIL to_length: got %0d want %0d", ones, HOLD); errors++; end
    checks++; if (timeout !== 1'b1) begin $display("FAIL to_pulse: got %0b want 1", timeout); errors++; end
    tick();
    checks++; if (timeout !== 1'b0) begin $display("FAIL to_pulse_end: got %0b want 0", timeout); errors++; end
    checks++; if (gnt !== 8'd0) begin $display("FAIL to_gap: got %0h want 0", gnt); errors++; end
    tick();
    owner = exp_q.pop_front();
    checks++;
    if (gnt !== (8'd1 << owner)) begin
      $display("FAIL to_regrant: got %0h want %0h", gnt, 8'd1 << owner); errors++;
    end
    // Release on the same edge the counter would expire: no pulse.
    for (int i = 0; i < int'(HOLD) - 1; i++) tick();
    req = 8'd0;
    tick();
    checks++; if (gnt !== 8'd0) begin $display("FAIL to_coincide_gnt: got %0h want 0", gnt); errors++; end
    checks++;
    if (timeout !== 1'b0) begin $display("FAIL to_coincide_pulse: got %0b want 0", timeout); errors++; end
`else
    int bad;
    exp_q.push_back(2);
    req = 8'h04;
    wait_gnt(4, n);
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL to_sel: got %0d want %0d", sel, owner); errors++; end
    bad = 0;
    for (int i = 0; i < 4 * int'(HOLD); i++) begin
      tick();
      if (gnt !== 8'h04 || timeout !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin $display("FAIL no_timeout_hold: got %0d bad cycles want 0", bad); errors++; end
    req = 8'd0;
    tick();
`endif
    drain();
  endtask

  task automatic test_async_reset();
    int n;
    int owner;
    exp_q.push_back(6);
    exp_q.push_back(6);
    req = 8'h40;
    wait_gnt(4, n);
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL ar_sel: got %0d want %0d", sel, owner); errors++; end
    #2;
    sys_rst = 1'b1;
    #1;
    checks++; if (gnt !== 8'd0) begin $display("FAIL ar_gnt: got %0h want 0", gnt); errors++; end
    checks++; if (sel !== 3'd0) begin $display("FAIL ar_sel_rst: got %0d want 0", sel); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL ar_busy: got %0b want 0", busy); errors++; end
    tick();
    sys_rst = 1'b0;
    tick();
    owner = exp_q.pop_front();
    checks++;
    if (sel !== 3'(owner)) begin $display("FAIL ar_regrant_sel: got %0d want %0d", sel, owner); errors++; end
    checks++;
    if (gnt !== (8'd1 << owner)) begin
      $display("FAIL ar_regrant_gnt: got %0h want %0h", gnt, 8'd1 << owner); errors++;
    end
    checks++; if (busy !== 1'b1) begin $display("FAIL ar_regrant_busy: got %0b want 1", busy); errors++; end
    req = 8'd0;
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_ptr_wrap();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dec_sel_arbiter.md
# dec_sel_arbiter

Round-robin arbiter/sequencer for the 3-to-8 select decoder datapath. Eight requesters compete for the decoder. The block grants one at a time, drives the registered 3-bit select and a one-hot grant, and holds the grant while the owner keeps requesting. It enforces a break-before-make gap between owners and sits directly in front of the decoder, with sel[0]/sel[1]/sel[2] feeding in1/in2/in3.

## Interface
- HOLD_MAX, 16'd1000: maximum grant length in clocks (used only with the timeout feature; legal 1..65535).
- GAP_CYC, 4'd1: clocks with no grant between two owners (legal 1..15).
- sys_clk  input  1  single clock, all logic on rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- req  input  8  request per requester, level; held high for as long as the requester wants the decoder.
- sel  output  3  registered index of current owner; reset 3'd0; holds last value when idle.
- gnt  output  8  registered one-hot grant, equals 1<<sel while busy, else 8'd0; reset 8'd0.
- busy  output  1  registered, high while a grant is active; reset 0.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX; reset 0.

## Operation
- FSM states IDLE, BUSY, GAP; reset state IDLE.
- IDLE: if req != 0, pick a winner and go to BUSY; otherwise stay in IDLE.
- BUSY: leave when req[sel]==0 or the hold counter reaches HOLD_MAX. On leaving, clear gnt/busy and go to GAP.
- GAP: count GAP_CYC clocks with gnt=0. On the last gap clock, pick a winner and go to BUSY if req != 0; otherwise go to IDLE.
- Round-robin pointer ptr[2:0], reset 0. Search req from ptr upward modulo 8; the first set bit wins.
- On each grant to index k, ptr <= k+1, wrapping 7 -> 0.
- Hold counter (16 bit) clears on grant and increments each BUSY clock. It saturates and never wraps.
- A requester that drops and re-raises req during GAP is treated as a fresh request.
- Requests raised while BUSY wait; there is no preemption.
- Release and timeout in the same clock count as a release; no timeout pulse is issued.
- Reset mid-grant: outputs return to reset values immediately (asynchronously); ptr returns to 0.

## Timing
- Request-to-grant latency: req sampled high in IDLE at edge N -> gnt/sel/busy valid after edge N.
- Release latency: req[sel] sampled low at edge M -> gnt = 0 after edge M.
- Gap: gnt is 0 for exactly GAP_CYC clocks between consecutive owners. The next gnt appears after the edge that ends the gap.
- Timeout: gnt drops after the edge on which the counter equals HOLD_MAX, so the grant lasts HOLD_MAX clocks. timeout is high for that one following cycle only.
- sel updates only on a grant edge and never changes while busy=1.

## Configuration
- DEC_ARB_TIMEOUT_EN defined: the hold counter and forced revocation are active, and timeout pulses as specified.
- DEC_ARB_TIMEOUT_EN undefined: the counter is not built, the grant lasts until release only, and timeout is tied to 0.

## Structure
- Package dec_arb_pkg holds:
  - N_REQ = 8 and SEL_W = 3;
  - the state encoding IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2;
  - the default HOLD_MAX and GAP_CYC constants.
- One sub-module: rr_pick8, combinational. Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0].
- The top level holds the FSM, ptr, hold and gap counters, and output registers.

## Test plan
- Reset then single request: req = 8'h08 -> sel = 3 and gnt = 8'h08 one clock later. Drop req -> gnt = 0 one clock later.
- Rotation: req = 8'hFF, each owner releases after 2 clocks -> grant order 0, 1, …, 7, 0. gnt = 0 for exactly GAP_CYC clocks between owners.
- Pointer wrap: grant 7, then req = 8'h81 -> next owner 0, not 7.
- Timeout (macro defined, HOLD_MAX = 5, req = 8'h04 held) -> gnt high for exactly 5 clocks, timeout pulses for 1 clock, regrant after the gap.
- No macro, same stimulus -> gnt stays 8'h04 indefinitely and timeout stays 0.
- Async reset asserted mid-BUSY (owner 6) -> gnt = 0, sel = 0, busy = 0 without waiting for a clock. After release with req = 8'h40, owner 6 is regranted one clock later.
